lcd_write_byte: RTL



---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_delay_timer.sv | 26 ++
 rtl/lcd_write_byte.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD write path: state encoding,
// default timing (cycles at 50 MHz), command codes and delay-counter helpers.
package lcd_pkg;

  localparam int DELAY_W = 17;

  localparam int SETUP_CYC_DEF       = 2;
  localparam int PULSE_CYC_DEF       = 12;
  localparam int HOLD_CYC_DEF        = 1;
  localparam int GAP_CYC_DEF         = 50;
  localparam int SETTLE_CYC_DEF      = 2000;
  localparam int LONG_SETTLE_CYC_DEF = 82000;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef logic [DELAY_W-1:0] delay_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HI_SETUP,
    ST_HI_PULSE,
    ST_HI_HOLD,
    ST_GAP,
    ST_LO_SETUP,
    ST_LO_PULSE,
    ST_LO_HOLD,
    ST_SETTLE,
    ST_DONE
  } lcd_state_t;

  // The down-counter advances on reaching zero, so a phase of N cycles loads N-1.
  function automatic delay_t cycles_to_load(input int unsigned cycles);
    return delay_t'(cycles - 1);
  endfunction

  // Clear display and both return-home encodings (0x02, 0x03) need the long wait.
  function automatic logic is_long_cmd(input logic [7:0] value, input logic rs);
    return !rs && (value == CMD_CLEAR || value == CMD_HOME || value == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable 17-bit down-counter with a zero flag; shared by the LCD sequencing
// blocks (byte writer, power-on init, display config).
module lcd_delay_timer
  import lcd_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  delay_t value,
  output delay_t count,
  output logic   zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - delay_t'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_write_byte.sv
// Writes one byte to an HD44780-style LCD in 4-bit mode (high nibble first),
// then pulses writeByteDone. Define LCD_WRITE_BYTE_LONG_CMD_EN for long clear/home settle.
module lcd_write_byte
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC       = SETUP_CYC_DEF,
  parameter int PULSE_CYC       = PULSE_CYC_DEF,
  parameter int HOLD_CYC        = HOLD_CYC_DEF,
  parameter int GAP_CYC         = GAP_CYC_DEF,
  parameter int SETTLE_CYC      = SETTLE_CYC_DEF,
  parameter int LONG_SETTLE_CYC = LONG_SETTLE_CYC_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       doWriteByte,
  input  logic       lcdRegSel,
  input  logic [7:0] dataIn,
  output logic       writeByteDone,
  output logic       lcdE,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic [3:0] lcdData
);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || GAP_CYC < 1 ||
      SETTLE_CYC < 1 || LONG_SETTLE_CYC < 1) begin : g_bad_timing
    $error("lcd_write_byte: every timing parameter must be at least 1");
  end

  lcd_state_t state, state_next;
  logic [7:0] byte_reg;
  logic       rs_reg;
  logic       timer_load;
  logic       timer_zero;
  delay_t     timer_value;
  delay_t     timer_count;
  delay_t     settle_load;
  logic [7:0] byte_src;
  logic       rs_src;

  lcd_delay_timer u_timer (
    .clk   (CLK),
    .reset (RESET),
    .load  (timer_load),
    .value (timer_value),
    .count (timer_count),
    .zero  (timer_zero)
  );

`ifdef LCD_WRITE_BYTE_LONG_CMD_EN
  assign settle_load = is_long_cmd(byte_reg, rs_reg) ? cycles_to_load(LONG_SETTLE_CYC)
                                                     : cycles_to_load(SETTLE_CYC);
`else
  assign settle_load = cycles_to_load(SETTLE_CYC);
`endif

  // On the accept edge the byte is not latched yet, so outputs come straight from the inputs.
  assign byte_src = (state == ST_IDLE) ? dataIn : byte_reg;
  assign rs_src   = (state == ST_IDLE) ? lcdRegSel : rs_reg;
  assign lcdRW    = 1'b0;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state)
      ST_IDLE: if (doWriteByte) begin
        state_next  = ST_HI_SETUP;
        timer_load  = 1'b1;
        timer_value = cycles_to_load(SETUP_CYC);
      end
      ST_HI_SETUP: if (timer_zero) begin
        state_next  = ST_HI_PULSE;
        timer_load  = 1'b1;
        timer_value = cycles_to_load(PULSE_CYC);
      end
      ST_HI_PULSE: if (timer_zero) begin
        state_next  = ST_HI_HOLD;
        timer_load  = 1'b1;
        timer_value = cycles_to_load(HOLD_CYC);
      end
      ST_HI_HOLD: if (timer_zero) begin
        state_next  = ST_GAP;
        timer_load  = 1'b1;
        timer_value = cycles_to_load(GAP_CYC);
      end
      ST_GAP: if (timer_zero) begin
        state_next  = ST_LO_SETUP;
        timer_load  = 1'b1;
        timer_value = cycles_to_load(SETUP_CYC);
      end
      ST_LO_SETUP: if (timer_zero) begin
        state_next  = ST_LO_PULSE;
        timer_load  = 1'b1;
        timer_value = cycles_to_load(PULSE_CYC);
      end
      ST_LO_PULSE: if (timer_zero) begin
        state_next  = ST_LO_HOLD;
        timer_load  = 1'b1;
        timer_value = cycles_to_load(HOLD_CYC);
      end
      ST_LO_HOLD: if (timer_zero) begin
        state_next  = ST_SETTLE;
        timer_load  = 1'b1;
        timer_value = settle_load;
      end
      ST_SETTLE: if (timer_zero) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      byte_reg      <= '0;
      rs_reg        <= 1'b0;
      writeByteDone <= 1'b0;
      lcdE          <= 1'b0;
      lcdRS         <= 1'b0;
      lcdData       <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state         <= state_next;
      lcdE          <= (state_next == ST_HI_PULSE) || (state_next == ST_LO_PULSE);
      writeByteDone <= (state_next == ST_DONE);
      if (state == ST_IDLE && doWriteByte) begin
        byte_reg <= dataIn;
        rs_reg   <= lcdRegSel;
      end
      if (state_next != ST_IDLE) begin
        lcdRS   <= rs_src;
        lcdData <= (state_next inside {ST_HI_SETUP, ST_HI_PULSE, ST_HI_HOLD, ST_GAP})
                   ? byte_src[7:4] : byte_src[3:0];
      end
    end
  end

endmodule
